// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared types and constants for the frame sequencer
// Contents: sequencer state enum, default parameter values, watchdog width helper.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2
    } seq_state_e;

    localparam int DEF_N_STAGES       = 2;
    localparam int DEF_SERIAL         = 1;
    localparam int DEF_FRAME_CNT_W    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 0;

    // Watchdog counter width; kept at least one bit so a disabled watchdog
    // still has a legal (unused) register.
    function automatic int wd_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_seq_stage.sv
// rtl/frame_seq_stage.sv - per-stage launch/completion slice of the frame sequencer
// Ports: clock, reset (sync active-high); load/load_bit latch the stage's mask bit at
// frame start; run enables launching; kill drops pending on watchdog expiry; grant
// permits launch (serial priority); start_ack/done from the stage; start, pending,
// done_ack registered outputs.
module frame_seq_stage (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic load_bit,
    input  logic run,
    input  logic kill,
    input  logic grant,
    input  logic start_ack,
    input  logic done,
    output logic start,
    output logic pending,
    output logic done_ack
);

    logic start_q, start_d;
    logic pending_q, pending_d;
    logic started_q, started_d;
    logic done_ack_q, done_ack_d;

    always_comb begin
        // Ack a held done exactly once; the stage drops done during the ack cycle.
        done_ack_d = done & ~done_ack_q;
        started_d  = started_q | (start_q & start_ack);
        // Only a launched stage can retire its pending bit; stray dones are just acked.
        pending_d  = pending_q & ~(started_q & done_ack_d);
        start_d    = 1'b0;
        if (load) begin
            pending_d = load_bit;
            started_d = 1'b0;
            start_d   = load_bit & grant;
        end else if (kill) begin
            pending_d = 1'b0;
        end else if (run) begin
            start_d = pending_q & ~started_d & grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q    <= 1'b0;
            pending_q  <= 1'b0;
            started_q  <= 1'b0;
            done_ack_q <= 1'b0;
        end else begin
            start_q    <= start_d;
            pending_q  <= pending_d;
            started_q  <= started_d;
            done_ack_q <= done_ack_d;
        end
    end

    assign start    = start_q;
    assign pending  = pending_q;
    assign done_ack = done_ack_q;

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame-level launch/collect/swap sequencer for the frame store
// Ports: clock, reset (sync active-high); enable, stage_mask start a frame from IDLE;
// start/start_ack and done/done_ack per-stage handshakes; swap/swap_ack to the reader;
// frame_count completed swaps; timeout_flags sticky per-stage watchdog hits; busy.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int N_STAGES       = DEF_N_STAGES,
    parameter int SERIAL         = DEF_SERIAL,
    parameter int FRAME_CNT_W    = DEF_FRAME_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N_STAGES-1:0]    stage_mask,
    output logic [N_STAGES-1:0]    start,
    input  logic [N_STAGES-1:0]    start_ack,
    input  logic [N_STAGES-1:0]    done,
    output logic [N_STAGES-1:0]    done_ack,
    output logic                   swap,
    input  logic                   swap_ack,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [N_STAGES-1:0]    timeout_flags,
    output logic                   busy
);

    localparam int WD_W = wd_width(TIMEOUT_CYCLES);

    seq_state_e             state_q, state_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [N_STAGES-1:0]    timeout_flags_q, timeout_flags_d;
    logic                   swap_q, swap_d;
    logic                   busy_q, busy_d;

    logic [N_STAGES-1:0]    pending_vec;
    logic [N_STAGES-1:0]    grant_src;
    logic [N_STAGES-1:0]    grant;
    logic                   load;
    logic                   run;
    logic                   timeout_hit;

    assign load = (state_q == IDLE) & enable;
    assign run  = (state_q == RUN);

    // Serial mode grants only the lowest set bit: of the new mask at frame start,
    // of the registered pending set afterwards, so the next stage launches the
    // cycle after the previous stage's done_ack.
    assign grant_src = load ? stage_mask : pending_vec;
    assign grant     = (SERIAL != 0) ? (grant_src & (~grant_src + N_STAGES'(1))) : '1;

    always_comb begin
        timeout_hit = 1'b0;
        if ((TIMEOUT_CYCLES > 0) && run && (pending_vec != '0) &&
            (int'(wd_q) == TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
        end
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        frame_seq_stage u_stage (
            .clock     (clock),
            .reset     (reset),
            .load      (load),
            .load_bit  (stage_mask[i]),
            .run       (run),
            .kill      (timeout_hit),
            .grant     (grant[i]),
            .start_ack (start_ack[i]),
            .done      (done[i]),
            .start     (start[i]),
            .pending   (pending_vec[i]),
            .done_ack  (done_ack[i])
        );
    end

    always_comb begin
        state_d         = state_q;
        wd_d            = wd_q;
        frame_count_d   = frame_count_q;
        timeout_flags_d = timeout_flags_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    wd_d    = '0;
                    state_d = (stage_mask != '0) ? RUN : SWAP;
                end
            end
            RUN: begin
                wd_d = wd_q + WD_W'(1);
                if (pending_vec == '0) begin
                    state_d = SWAP;
                end else if (timeout_hit) begin
                    timeout_flags_d = timeout_flags_q | pending_vec;
                    state_d         = SWAP;
                end
            end
            SWAP: begin
                if (swap_ack) begin
                    frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        swap_d = (state_d == SWAP);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            wd_q            <= '0;
            frame_count_q   <= '0;
            timeout_flags_q <= '0;
            swap_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wd_q            <= wd_d;
            frame_count_q   <= frame_count_d;
            timeout_flags_q <= timeout_flags_d;
            swap_q          <= swap_d;
            busy_q          <= busy_d;
        end
    end

    assign swap          = swap_q;
    assign busy          = busy_q;
    assign frame_count   = frame_count_q;
    assign timeout_flags = timeout_flags_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized self-checking bench for frame_sequencer
module tb_frame_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       en    [2];
    logic [1:0] msk   [2];
    logic [1:0] sack  [2];
    logic [1:0] dn    [2];
    logic       swack [2];

    wire  [1:0]  st0, da0, tf0, st1, da1, tf1;
    wire         sw0, bz0, sw1, bz1;
    wire  [1:0]  fc0;
    wire  [15:0] fc1;

    // dut0: serial, no watchdog, 2-bit frame counter
    frame_sequencer #(.N_STAGES(2), .SERIAL(1), .FRAME_CNT_W(2), .TIMEOUT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst[0]), .enable(en[0]), .stage_mask(msk[0]),
        .start(st0), .start_ack(sack[0]), .done(dn[0]), .done_ack(da0),
        .swap(sw0), .swap_ack(swack[0]), .frame_count(fc0), .timeout_flags(tf0), .busy(bz0)
    );

    // dut1: parallel, 20-cycle watchdog, 16-bit frame counter
    frame_sequencer #(.N_STAGES(2), .SERIAL(0), .FRAME_CNT_W(16), .TIMEOUT_CYCLES(20)) dut1 (
        .clock(clk), .reset(rst[1]), .enable(en[1]), .stage_mask(msk[1]),
        .start(st1), .start_ack(sack[1]), .done(dn[1]), .done_ack(da1),
        .swap(sw1), .swap_ack(swack[1]), .frame_count(fc1), .timeout_flags(tf1), .busy(bz1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [1:0]  o_st, o_da, o_tf;
    logic        o_sw, o_bz;
    logic [15:0] o_fc;

    task automatic sample(input int d);
        if (d == 0) begin
            o_st = st0; o_da = da0; o_tf = tf0; o_sw = sw0; o_bz = bz0; o_fc = {14'b0, fc0};
        end else begin
            o_st = st1; o_da = da1; o_tf = tf1; o_sw = sw1; o_bz = bz1; o_fc = fc1;
        end
    endtask

    // Frame-level model state: swaps retired and sticky timeout set per DUT.
    int         frames  [2];
    logic [1:0] flags_m [2];
    int         fc_mod  [2];

    function automatic logic [1:0] lowest(input logic [1:0] v);
        return v & (~v + 2'd1);
    endfunction

    task automatic clear_inputs(input int d);
        en[d] = 1'b0; msk[d] = 2'b00; sack[d] = 2'b00; dn[d] = 2'b00; swack[d] = 1'b0;
    endtask

    // Runs one frame on DUT d with mask m; stages in hang accept start but never
    // finish; reset_at > 0 asserts reset at that cycle and checks the reset result.
    task automatic run_frame(input int d, input logic [1:0] m, input logic [1:0] hang,
                             input int reset_at);
        int         ackd [2];
        int         cnt  [2];
        logic [1:0] acc, comp, hold, prev_da;
        int         swap_due, sdelay, to;
        bit         ser, retire, expect_next1;
        ser = (d == 0);
        to  = (d == 0) ? 0 : 20;
        for (int i = 0; i < 2; i++) begin
            ackd[i] = (reset_at > 0) ? 3 : int'($urandom_range(0, 3));
            cnt[i]  = 0;
        end
        acc = 0; comp = 0; hold = 0;
        swap_due = (m == 2'b00) ? 1 : 1000000;
        sdelay = -1; retire = 0; expect_next1 = 0;
        sample(d);
        prev_da = o_da;
        msk[d] = m;
        en[d]  = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            sample(d);
            if (reset_at > 0 && n == reset_at + 1) begin
                check("rst_start", o_st, 0);
                check("rst_done_ack", o_da, 0);
                check("rst_swap", o_sw, 0);
                check("rst_busy", o_bz, 0);
                check("rst_frame_count", o_fc, 0);
                check("rst_timeout_flags", o_tf, 0);
                rst[d] = 1'b0;
                clear_inputs(d);
                frames[d]  = 0;
                flags_m[d] = 2'b00;
                return;
            end
            if (retire) begin
                swack[d] = 1'b0;
                check("swap_low", o_sw, 0);
                check("busy_low", o_bz, 0);
                check("start_after", o_st, 0);
                check("frame_count", o_fc, frames[d] % fc_mod[d]);
                check("timeout_flags", o_tf, flags_m[d]);
                return;
            end
            if (n == 1) begin
                check("busy_rise", o_bz, 1);
                check("start_first", o_st, (m == 2'b00) ? 2'b00 : (ser ? lowest(m) : m));
                check("frame_count_hold", o_fc, frames[d] % fc_mod[d]);
            end
            // Watchdog: stages not retired by RUN cycle 'to' are flagged, swap follows.
            if (to > 0 && n == to + 1 && swap_due > n) begin
                swap_due   = n;
                flags_m[d] = flags_m[d] | (m & ~comp);
            end
            for (int i = 0; i < 2; i++)
                check("done_ack", o_da[i], dn[d][i] & ~prev_da[i]);
            check("swap", o_sw, n >= swap_due);
            check("busy", o_bz, 1);
            if (n >= swap_due) check("start_idle", o_st, 0);
            if (ser && m[0] && !comp[0]) check("serial_order", o_st[1], 0);
            if (expect_next1) begin
                check("serial_next", o_st[1], 1);
                expect_next1 = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (hold[i] && o_da[i]) begin
                    hold[i]  = 1'b0;
                    dn[d][i] = 1'b0;
                    comp[i]  = 1'b1;
                    if (ser && i == 0 && m[1] && !comp[1]) expect_next1 = 1;
                end
                if (acc[i]) begin
                    check("start_drop", o_st[i], 0);
                    sack[d][i] = 1'b0;
                    if (!hold[i] && !comp[i] && !hang[i]) begin
                        if (cnt[i] <= 1) begin
                            dn[d][i] = 1'b1;
                            hold[i]  = 1'b1;
                        end else begin
                            cnt[i]--;
                        end
                    end
                end else if (o_st[i]) begin
                    if (ackd[i] == 0) begin
                        sack[d][i] = 1'b1;
                        acc[i]     = 1'b1;
                        cnt[i]     = int'($urandom_range(1, 5));
                    end else begin
                        ackd[i]--;
                    end
                end
            end
            prev_da = o_da;
            if (m != 2'b00 && (m & ~comp) == 2'b00 && swap_due > n + 1) swap_due = n + 1;
            en[d]  = 1'(($urandom_range(0, 1)));
            msk[d] = 2'($urandom);
            if (o_sw) begin
                if (sdelay < 0) sdelay = int'($urandom_range(0, 2));
                if (sdelay == 0) begin
                    swack[d] = 1'b1;
                    en[d]    = 1'b0;
                    retire   = 1;
                    frames[d]++;
                end else begin
                    sdelay--;
                end
            end
            if (reset_at > 0 && n == reset_at) rst[d] = 1'b1;
        end
        check("frame_budget", 0, 1);
    endtask

    initial begin
        fc_mod[0] = 4;
        fc_mod[1] = 65536;
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d]     = 1'b1;
            frames[d]  = 0;
            flags_m[d] = 2'b00;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            check("reset_start", o_st, 0);
            check("reset_done_ack", o_da, 0);
            check("reset_swap", o_sw, 0);
            check("reset_busy", o_bz, 0);
            check("reset_frame_count", o_fc, 0);
            check("reset_timeout_flags", o_tf, 0);
        end

        // Serial DUT: full mask, swap-only frame, then random masks through the wrap.
        run_frame(0, 2'b11, 2'b00, 0);
        run_frame(0, 2'b00, 2'b00, 0);
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_frame(0, 2'($urandom), 2'b00, 0);
        end
        // Reset while stage 0 still has start raised.
        run_frame(0, 2'b11, 2'b00, 2);
        @(negedge clk);
        run_frame(0, 2'b11, 2'b00, 0);

        // Parallel DUT: full mask, random masks, then a hung stage 1.
        run_frame(1, 2'b11, 2'b00, 0);
        for (int k = 0; k < 6; k++) run_frame(1, 2'($urandom), 2'b00, 0);
        run_frame(1, 2'b11, 2'b10, 0);
        // Late done from the timed-out stage: one ack, nothing else changes.
        @(negedge clk);
        dn[1][1] = 1'b1;
        @(negedge clk);
        sample(1);
        check("late_done_ack", o_da[1], 1);
        dn[1][1] = 1'b0;
        @(negedge clk);
        sample(1);
        check("late_done_ack_once", o_da[1], 0);
        check("late_busy", o_bz, 0);
        check("late_flags", o_tf, 2'b10);
        clear_inputs(1);
        run_frame(1, 2'b11, 2'b00, 0);
        run_frame(1, 2'b01, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised frame-level sequencer for the video pipeline's double-buffered SRAM frame store. Generalises the fixed two-writer swap sequencing to N_STAGES producer stages (background writer, overlay, later filters), run either serially or in parallel. Each frame it launches the enabled stages, collects their completions, optionally times out a hung stage, then requests a buffer swap from the DVI-side reader. Sits on the 10 MHz writer clock domain between the stage blocks and the image-buffer reader's swap/swap_ack pair.

## Interface
- N_STAGES, 2: number of producer stages (1..8).
- SERIAL, 1: 1 = stages run one at a time in ascending index; 0 = all enabled stages start together.
- FRAME_CNT_W, 16: width of frame_count.
- TIMEOUT_CYCLES, 0: per-frame RUN watchdog in clock cycles; 0 disables.

- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits a new frame to start; sampled in IDLE only.
- stage_mask  in  N_STAGES  stages participating; latched at frame start.
- start  out  N_STAGES  per-stage launch request, held until acked.
- start_ack  in  N_STAGES  stage accepted start.
- done  in  N_STAGES  stage finished its frame; held until done_ack.
- done_ack  out  N_STAGES  one-cycle completion acknowledge.
- swap  out  1  buffer-swap request to reader, held until acked.
- swap_ack  in  1  reader accepted swap.
- frame_count  out  FRAME_CNT_W  completed swaps, wraps modulo 2^FRAME_CNT_W.
- timeout_flags  out  N_STAGES  sticky: stage was timed out at least once.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, SWAP. Registers: active (latched mask), pending, started, watchdog counter.
- IDLE: if enable: active <= stage_mask, pending <= stage_mask, started <= 0, watchdog <= 0. If stage_mask != 0 -> RUN, else -> SWAP (swap-only frame).
- RUN, launch: parallel: start[i] = pending[i] & ~started[i]. Serial: only the lowest-index pending stage may be launched. start_ack[i] high while start[i] high -> started[i] set, start[i] low next cycle.
- RUN, completion: done_ack[i] <= done[i] & ~done_ack[i] in every state, so a stage holding done is acked once; stage drops done in the ack cycle. If pending[i] & started[i], pending[i] clears with the ack. done from a non-pending stage is acked and otherwise ignored.
- RUN -> SWAP when pending == 0.
- Watchdog (TIMEOUT_CYCLES > 0): increments each RUN cycle; on reaching TIMEOUT_CYCLES, timeout_flags |= pending, pending <= 0, all start low, -> SWAP.
- SWAP: swap high; on swap_ack sampled high: swap low, frame_count += 1, -> IDLE.
- Serial order: next stage's start asserts the cycle after previous stage's done_ack.

## Timing
- Reset: start=0, done_ack=0, swap=0, frame_count=0, timeout_flags=0, busy=0, state IDLE; takes effect on next edge even mid-frame.
- All outputs registered. enable sampled high at cycle t in IDLE -> busy and start high at t+1.
- start_ack at k -> start low at k+1. done at k -> done_ack high at k+1 only.
- Last pending cleared at k+1 -> swap high at k+2. swap_ack at m -> swap low, frame_count updated, IDLE at m+1; next start no earlier than m+2.
- Minimum frame, one stage acking combinationally: 5 cycles enable-to-swap-ack-retire.
- stage_mask/enable changes during RUN/SWAP have no effect.

## Structure
- Package frame_seq_pkg: state enum (IDLE, RUN, SWAP), default parameter constants, watchdog width function $clog2(TIMEOUT_CYCLES+1).
- Sub-module frame_seq_stage: per-stage start/started/pending/done_ack slice, instantiated N_STAGES times via generate; top holds FSM, serial priority select (lowest set bit), watchdog, frame counter.

## Test plan
- N_STAGES=2, SERIAL=1, mask=2'b11, stages ack/done after 3 and 5 cycles -> start[1] never rises before done_ack[0]; single swap; frame_count=1.
- SERIAL=0, mask=2'b11 -> start=2'b11 in same cycle; done[1] before done[0] -> swap only after both acks; done_ack each exactly one cycle.
- mask=2'b00, enable=1 -> no start, swap within 1 cycle of IDLE exit; frame_count increments.
- TIMEOUT_CYCLES=20, stage 1 never asserts done -> swap at watchdog expiry, timeout_flags=2'b10 persists; later late done[1] acked once, frame otherwise unaffected.
- FRAME_CNT_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1.
- Reset asserted in RUN with start high -> next cycle all outputs 0, busy=0, frame_count=0.
